sa_feeder_2x2: RTL and testbench
================================

SA_FEEDER_2X2 -- requirements
Module: sa_feeder_2x2

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of every data word.
REQ-002 Parameter CNT_WIDTH, default 16, width of the beat counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset. Ports are listed below, clock and reset first.
REQ-004 sa_clk  in  1  clock; all state updates on rising edge.
REQ-005 sa_rst  in  1  asynchronous active-low reset.
REQ-006 w_valid  in  1  weight-row beat valid.
REQ-007 w_ready  out  1  weight-row beat accepted when w_valid&w_ready at rising edge.
REQ-008 w_0, w_1  in  DATA_WIDTH  weight row (column 0 / column 1).
REQ-009 in_valid  in  1  activation-vector beat valid.
REQ-010 in_ready  out  1  activation beat accepted when in_valid&in_ready at rising edge.
REQ-011 in_data_0, in_data_1  in  DATA_WIDTH  activation vector (row 0 / row 1).
REQ-012 in_last  in  1  marks final activation beat of a job; sampled only on an accepted beat.
REQ-013 sa_FDi_0, sa_FDi_1  out  DATA_WIDTH  weight feed to array columns.
REQ-014 sa_load  out  1  array weight-shift strobe.
REQ-015 sa_RD_0, sa_RD_1  out  DATA_WIDTH  skewed activation feed to array rows.
REQ-016 rd_valid_0, rd_valid_1  out  1  qualifiers for sa_RD_0 / sa_RD_1.
REQ-017 done  out  1  one-cycle pulse at the end of a job.
REQ-018 beat_cnt  out  CNT_WIDTH  beats accepted in the current or last job; saturating.

Function
REQ-019 FSM states: IDLE, W1, STREAM, DRAIN. Flag wloaded records that a complete weight set is held.
REQ-020 Every output SHALL be registered. There is no combinational path from an input to sa_* or rd_valid_*.
REQ-021 IDLE: w_ready=1, in_ready=wloaded & ~w_valid. When both are valid, a weight beat takes priority.
REQ-022 Weight beat accepted in IDLE -> next cycle sa_load=1 and sa_FDi_0/1=w_0/w_1. State goes to W1 and wloaded clears. This first beat is the bottom-row weights.
REQ-023 W1: w_ready=1, in_ready=0. Beat accepted -> next cycle sa_load=1 and sa_FDi_0/1=w_0/w_1. wloaded sets and state goes to IDLE.
REQ-024 Outside the cycle after an accepted weight beat: sa_load=0 and sa_FDi_0/1=0.
REQ-025 Activation beat accepted in IDLE -> beat_cnt reloads to 1 and state goes to STREAM. If in_last=1 on that beat, state goes directly to DRAIN.
REQ-026 STREAM: in_ready=1, w_ready=0. The block applies no backpressure.
REQ-027 Skew for a beat accepted at edge t:
- sa_RD_0=in_data_0 with rd_valid_0=1 in cycle t+1.
- sa_RD_1=in_data_1 with rd_valid_1=1 in cycle t+2.
REQ-028 A cycle with no accepted beat (bubble) -> that lane slot carries data 0 with valid 0 one/two cycles later. Skew alignment is preserved.
REQ-029 Accepted beat with in_last=1 in STREAM -> state goes to DRAIN. beat_cnt increments, saturating at all-ones.
REQ-030 DRAIN lasts exactly one cycle with in_ready=0 and w_ready=0, then goes to IDLE.
REQ-031 done=1 in the cycle that lane-1 carries the last beat (t+2), and only that cycle.
REQ-032 In IDLE after a job, wloaded remains set. Further jobs reuse the weights without reloading.
REQ-033 A new weight load SHALL be accepted only in IDLE or W1, never during STREAM or DRAIN.
REQ-034 in_last on a non-accepted cycle SHALL be ignored.

Reset
REQ-035 sa_rst=0 at any time, including mid-load or mid-stream, SHALL immediately force:
- state=IDLE and wloaded=0;
- all sa_* outputs=0, rd_valid_0/1=0, done=0, beat_cnt=0;
- w_ready=1 and in_ready=0.
REQ-036 Data in flight when reset asserts SHALL be discarded. After reset releases, no output reflects any pre-reset beat.

Verification
REQ-037 Weight load: beats (1,2) then (3,4), back-to-back from reset. Required response:
- sa_load=1 for two consecutive cycles;
- sa_FDi = (1,2) then (3,4);
- in_ready rises the cycle after the second acceptance.
REQ-038 Three-beat job: in_data=(10,20), (11,21), (12,22), last on beat 3. Required response:
- sa_RD_0 = 10, 11, 12 at t+1..t+3;
- sa_RD_1 = 20, 21, 22 at t+2..t+4;
- done at t+4;
- beat_cnt=3.
REQ-039 Bubble: beats (5,6), idle cycle, (7,8 last). Required response: rd_valid_0 pattern 1,0,1 and rd_valid_1 pattern 1,0,1, each shifted one cycle later.
REQ-040 Priority: w_valid and in_valid both high in IDLE with wloaded=1. Required response:
- weight beat accepted, in_ready=0;
- state goes to W1 and in_ready stays 0 until the second weight beat.
REQ-041 Reset mid-stream: assert sa_rst for one cycle after beat 2 of 4. Required response:
- all outputs 0 and no done;
- in_ready=0 until a fresh two-beat weight load completes.
REQ-042 Single-beat job (9,19) with last. Required response: RD_0=9 at t+1, RD_1=19 and done at t+2, in_ready=1 at t+2.

Source files
------------

// File: rtl/sa_feeder_2x2_if.sv
// Weight-row and activation-vector streams feeding the 2x2 systolic-array feeder.
// master drives beats; slave (the feeder) returns ready.
interface sa_feeder_2x2_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_0;
    logic [DATA_WIDTH-1:0] w_1;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data_0;
    logic [DATA_WIDTH-1:0] in_data_1;
    logic                  in_last;

    modport master (
        output w_valid, w_0, w_1, in_valid, in_data_0, in_data_1, in_last,
        input  w_ready, in_ready
    );

    modport slave (
        input  w_valid, w_0, w_1, in_valid, in_data_0, in_data_1, in_last,
        output w_ready, in_ready
    );
endinterface

// File: rtl/sa_feeder_2x2.sv
// Feeder for a 2x2 systolic array: loads two weight rows, then streams
// activation vectors with a one-cycle skew between row 0 and row 1.
module sa_feeder_2x2 #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  sa_clk,
    input  logic                  sa_rst,
    sa_feeder_2x2_if.slave        feed,
    output logic [DATA_WIDTH-1:0] sa_FDi_0,
    output logic [DATA_WIDTH-1:0] sa_FDi_1,
    output logic                  sa_load,
    output logic [DATA_WIDTH-1:0] sa_RD_0,
    output logic [DATA_WIDTH-1:0] sa_RD_1,
    output logic                  rd_valid_0,
    output logic                  rd_valid_1,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);
    typedef enum logic [1:0] {IDLE, W1, STREAM, DRAIN} state_t;

    state_t                state;
    logic                  wloaded;
    logic [DATA_WIDTH-1:0] rd1_q;
    logic                  rv1_q;
    logic                  last_q;
    logic                  w_acc;
    logic                  in_acc;

    // Ready is decoded from state; in IDLE a pending weight beat masks activations.
    assign feed.w_ready  = (state == IDLE) || (state == W1);
    assign feed.in_ready = (state == STREAM) ||
                           ((state == IDLE) && wloaded && !feed.w_valid);
    assign w_acc  = feed.w_valid  && feed.w_ready;
    assign in_acc = feed.in_valid && feed.in_ready;

    always_ff @(posedge sa_clk or negedge sa_rst) begin
        if (!sa_rst) begin
            state      <= IDLE;
            wloaded    <= 1'b0;
            sa_load    <= 1'b0;
            sa_FDi_0   <= '0;
            sa_FDi_1   <= '0;
            sa_RD_0    <= '0;
            sa_RD_1    <= '0;
            rd_valid_0 <= 1'b0;
            rd_valid_1 <= 1'b0;
            rd1_q      <= '0;
            rv1_q      <= 1'b0;
            last_q     <= 1'b0;
            done       <= 1'b0;
            beat_cnt   <= '0;
        end else begin
            sa_load    <= w_acc;
            sa_FDi_0   <= w_acc ? feed.w_0 : '0;
            sa_FDi_1   <= w_acc ? feed.w_1 : '0;
            // Lane 1 passes through an extra stage so done lines up with its last beat.
            sa_RD_0    <= in_acc ? feed.in_data_0 : '0;
            rd_valid_0 <= in_acc;
            rd1_q      <= in_acc ? feed.in_data_1 : '0;
            rv1_q      <= in_acc;
            last_q     <= in_acc && feed.in_last;
            sa_RD_1    <= rd1_q;
            rd_valid_1 <= rv1_q;
            done       <= last_q;

            case (state)
                IDLE: begin
                    if (w_acc) begin
                        state   <= W1;
                        wloaded <= 1'b0;
                    end else if (in_acc) begin
                        beat_cnt <= CNT_WIDTH'(1);
                        state    <= feed.in_last ? DRAIN : STREAM;
                    end
                end
                W1: begin
                    if (w_acc) begin
                        wloaded <= 1'b1;
                        state   <= IDLE;
                    end
                end
                STREAM: begin
                    if (in_acc) begin
                        if (beat_cnt != '1) beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                        if (feed.in_last) state <= DRAIN;
                    end
                end
                DRAIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sa_feeder_2x2.sv
// Randomized and directed checks of sa_feeder_2x2 against a slot-based
// behavioural model of the skewed feed, weight load and job counting.
module tb_sa_feeder_2x2;
    localparam int DW   = 16;
    localparam int CW   = 3;
    localparam int CMAX = 7;

    logic            sa_clk;
    logic            sa_rst;
    logic [DW-1:0]   sa_FDi_0, sa_FDi_1, sa_RD_0, sa_RD_1;
    logic            sa_load, rd_valid_0, rd_valid_1, done;
    logic [CW-1:0]   beat_cnt;

    sa_feeder_2x2_if #(.DATA_WIDTH(DW)) fi ();

    sa_feeder_2x2 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .sa_clk(sa_clk), .sa_rst(sa_rst), .feed(fi),
        .sa_FDi_0(sa_FDi_0), .sa_FDi_1(sa_FDi_1), .sa_load(sa_load),
        .sa_RD_0(sa_RD_0), .sa_RD_1(sa_RD_1),
        .rd_valid_0(rd_valid_0), .rd_valid_1(rd_valid_1),
        .done(done), .beat_cnt(beat_cnt)
    );

    initial sa_clk = 1'b0;
    always #5 sa_clk = ~sa_clk;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Expected outputs by edge number (mod 8): what the DUT shows after that edge.
    logic [DW-1:0] e_fdi0 [8], e_fdi1 [8], e_rd0 [8], e_rd1 [8];
    bit            e_load [8], e_rv0 [8], e_rv1 [8], e_done [8];

    // Abstract model: weight beats held toward the current set, job activity, drain cycle.
    int m_wbeats;
    bit m_in_job;
    bit m_drain;
    int m_cnt;

    function automatic bit m_w_ready();
        return !m_in_job && !m_drain;
    endfunction

    function automatic bit m_in_ready();
        return m_in_job || (!m_drain && (m_wbeats == 2) && !fi.w_valid);
    endfunction

    task automatic idle_inputs();
        fi.w_valid = 1'b0; fi.w_0 = '0; fi.w_1 = '0;
        fi.in_valid = 1'b0; fi.in_data_0 = '0; fi.in_data_1 = '0; fi.in_last = 1'b0;
    endtask

    task automatic set_w(input logic [DW-1:0] a, input logic [DW-1:0] b);
        fi.w_valid = 1'b1; fi.w_0 = a; fi.w_1 = b;
    endtask

    task automatic set_in(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit last);
        fi.in_valid = 1'b1; fi.in_data_0 = a; fi.in_data_1 = b; fi.in_last = last;
    endtask

    task automatic clear_model();
        m_wbeats = 0; m_in_job = 0; m_drain = 0; m_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            e_fdi0[i] = '0; e_fdi1[i] = '0; e_rd0[i] = '0; e_rd1[i] = '0;
            e_load[i] = 0; e_rv0[i] = 0; e_rv1[i] = 0; e_done[i] = 0;
        end
    endtask

    task automatic assert_reset();
        sa_rst = 1'b0;
        clear_model();
        #1;
    endtask

    // One clock: capture the beat, advance the model, return at the next falling edge.
    task automatic tick();
        bit wacc, iacc, last;
        logic [DW-1:0] w0, w1, d0, d1;
        int s0, s1;
        wacc = fi.w_valid && m_w_ready();
        iacc = fi.in_valid && m_in_ready();
        w0 = fi.w_0; w1 = fi.w_1; d0 = fi.in_data_0; d1 = fi.in_data_1; last = fi.in_last;
        @(posedge sa_clk);
        edge_n++;
        s0 = edge_n % 8;
        s1 = (edge_n + 1) % 8;
        e_load[s0] = 0; e_fdi0[s0] = '0; e_fdi1[s0] = '0; e_rd0[s0] = '0; e_rv0[s0] = 0;
        e_rd1[s1] = '0; e_rv1[s1] = 0; e_done[s1] = 0;
        if (!sa_rst) begin
            clear_model();
        end else begin
            m_drain = 0;
            if (wacc) begin
                e_load[s0] = 1; e_fdi0[s0] = w0; e_fdi1[s0] = w1;
                m_wbeats = (m_wbeats == 1) ? 2 : 1;
            end
            if (iacc) begin
                e_rd0[s0] = d0; e_rv0[s0] = 1;
                e_rd1[s1] = d1; e_rv1[s1] = 1; e_done[s1] = last;
                m_cnt = m_in_job ? ((m_cnt < CMAX) ? m_cnt + 1 : CMAX) : 1;
                if (last) begin m_in_job = 0; m_drain = 1; end
                else m_in_job = 1;
            end
        end
        #1;
        idle_inputs();
        @(negedge sa_clk);
    endtask

    task automatic load_weights(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [DW-1:0] c, input logic [DW-1:0] d);
        set_w(a, b); tick();
        set_w(c, d); tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        assert_reset();
        @(negedge sa_clk);
        total++;
        if ({sa_load, sa_FDi_0, sa_FDi_1, sa_RD_0, sa_RD_1, rd_valid_0, rd_valid_1, done, beat_cnt} !== '0) begin
            bad++; $display("FAIL reset_outputs: load=%0b fdi=%0d,%0d rd=%0d,%0d rv=%0b%0b done=%0b cnt=%0d want all 0",
                sa_load, sa_FDi_0, sa_FDi_1, sa_RD_0, sa_RD_1, rd_valid_0, rd_valid_1, done, beat_cnt);
        end
        total++;
        if (fi.w_ready !== 1'b1 || fi.in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready: w_ready=%0b in_ready=%0b want 1,0", fi.w_ready, fi.in_ready);
        end
        tick();
        sa_rst = 1'b1;
    endtask

    task automatic test_weight_load();
        set_w(1, 2); #1;
        total++;
        if (fi.w_ready !== 1'b1 || fi.in_ready !== 1'b0) begin
            bad++; $display("FAIL wload_ready0: w_ready=%0b in_ready=%0b want 1,0", fi.w_ready, fi.in_ready);
        end
        tick();
        total++;
        if (sa_load !== 1'b1 || sa_FDi_0 !== 16'd1 || sa_FDi_1 !== 16'd2 || fi.in_ready !== 1'b0) begin
            bad++; $display("FAIL wload_beat1: load=%0b fdi=%0d,%0d in_ready=%0b want 1,1,2,0", sa_load, sa_FDi_0, sa_FDi_1, fi.in_ready);
        end
        set_w(3, 4); tick();
        total++;
        if (sa_load !== 1'b1 || sa_FDi_0 !== 16'd3 || sa_FDi_1 !== 16'd4 || fi.in_ready !== 1'b1) begin
            bad++; $display("FAIL wload_beat2: load=%0b fdi=%0d,%0d in_ready=%0b want 1,3,4,1", sa_load, sa_FDi_0, sa_FDi_1, fi.in_ready);
        end
        tick();
        total++;
        if (sa_load !== 1'b0 || sa_FDi_0 !== 16'd0 || sa_FDi_1 !== 16'd0) begin
            bad++; $display("FAIL wload_after: load=%0b fdi=%0d,%0d want 0,0,0", sa_load, sa_FDi_0, sa_FDi_1);
        end
    endtask

    task automatic test_three_beat();
        for (int k = 0; k < 3; k++) begin
            set_in(DW'(10 + k), DW'(20 + k), k == 2); #1;
            total++;
            if (fi.in_ready !== 1'b1) begin
                bad++; $display("FAIL job3_ready%0d: in_ready=%0b want 1", k, fi.in_ready);
            end
            tick();
            total++;
            if (sa_RD_0 !== DW'(10 + k) || rd_valid_0 !== 1'b1 || done !== 1'b0 ||
                (k > 0 && (sa_RD_1 !== DW'(19 + k) || rd_valid_1 !== 1'b1))) begin
                bad++; $display("FAIL job3_beat%0d: rd0=%0d rv0=%0b rd1=%0d rv1=%0b done=%0b want %0d,1,%0d,%0b,0",
                    k, sa_RD_0, rd_valid_0, sa_RD_1, rd_valid_1, done, 10 + k, (k > 0) ? 19 + k : 0, k > 0);
            end
        end
        total++;
        if (fi.in_ready !== 1'b0 || fi.w_ready !== 1'b0) begin
            bad++; $display("FAIL job3_drain: in_ready=%0b w_ready=%0b want 0,0", fi.in_ready, fi.w_ready);
        end
        tick();
        total++;
        if (sa_RD_1 !== 16'd22 || rd_valid_1 !== 1'b1 || rd_valid_0 !== 1'b0 || done !== 1'b1 ||
            beat_cnt !== 3'd3 || fi.in_ready !== 1'b1) begin
            bad++; $display("FAIL job3_end: rd1=%0d rv1=%0b rv0=%0b done=%0b cnt=%0d in_ready=%0b want 22,1,0,1,3,1",
                sa_RD_1, rd_valid_1, rd_valid_0, done, beat_cnt, fi.in_ready);
        end
        tick();
        total++;
        if (done !== 1'b0 || rd_valid_1 !== 1'b0) begin
            bad++; $display("FAIL job3_done_pulse: done=%0b rv1=%0b want 0,0", done, rd_valid_1);
        end
    endtask

    task automatic test_bubble();
        logic [3:0] p0, p1;
        p0 = '0; p1 = '0;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) set_in(5, 6, 0);
            else if (k == 2) set_in(7, 8, 1);
            tick();
            p0 = {p0[2:0], rd_valid_0};
            p1 = {p1[2:0], rd_valid_1};
        end
        total++;
        if (p0 !== 4'b1010 || p1 !== 4'b0101 || done !== 1'b1 || sa_RD_1 !== 16'd8) begin
            bad++; $display("FAIL bubble: rv0=%b rv1=%b done=%0b rd1=%0d want 1010,0101,1,8", p0, p1, done, sa_RD_1);
        end
        tick();
    endtask

    task automatic test_priority();
        set_w(16'h55, 16'h66); set_in(1, 2, 1); #1;
        total++;
        if (fi.w_ready !== 1'b1 || fi.in_ready !== 1'b0) begin
            bad++; $display("FAIL prio_ready: w_ready=%0b in_ready=%0b want 1,0", fi.w_ready, fi.in_ready);
        end
        tick();
        total++;
        if (sa_load !== 1'b1 || sa_FDi_0 !== 16'h55 || sa_FDi_1 !== 16'h66 || rd_valid_0 !== 1'b0) begin
            bad++; $display("FAIL prio_accept: load=%0b fdi=%h,%h rv0=%0b want 1,55,66,0", sa_load, sa_FDi_0, sa_FDi_1, rd_valid_0);
        end
        set_in(1, 2, 1); #1;
        total++;
        if (fi.in_ready !== 1'b0) begin
            bad++; $display("FAIL prio_w1_block: in_ready=%0b want 0", fi.in_ready);
        end
        tick();
        set_w(16'h77, 16'h88); tick();
        total++;
        if (rd_valid_0 !== 1'b0 || sa_load !== 1'b1 || fi.in_ready !== 1'b1) begin
            bad++; $display("FAIL prio_reload: rv0=%0b load=%0b in_ready=%0b want 0,1,1", rd_valid_0, sa_load, fi.in_ready);
        end
    endtask

    task automatic test_reset_midstream();
        set_in(31, 41, 0); tick();
        set_in(32, 42, 0); tick();
        assert_reset();
        total++;
        if ({sa_load, sa_FDi_0, sa_FDi_1, sa_RD_0, sa_RD_1, rd_valid_0, rd_valid_1, done, beat_cnt} !== '0 ||
            fi.w_ready !== 1'b1 || fi.in_ready !== 1'b0) begin
            bad++; $display("FAIL rst_mid_async: rd=%0d,%0d rv=%0b%0b done=%0b cnt=%0d w_ready=%0b in_ready=%0b want zeros,1,0",
                sa_RD_0, sa_RD_1, rd_valid_0, rd_valid_1, done, beat_cnt, fi.w_ready, fi.in_ready);
        end
        tick();
        sa_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_in(DW'(33 + k), DW'(43 + k), k == 1); #1;
            total++;
            if (fi.in_ready !== 1'b0) begin
                bad++; $display("FAIL rst_mid_ready%0d: in_ready=%0b want 0", k, fi.in_ready);
            end
            tick();
            total++;
            if (rd_valid_0 !== 1'b0 || rd_valid_1 !== 1'b0 || done !== 1'b0 || sa_RD_1 !== 16'd0) begin
                bad++; $display("FAIL rst_mid_quiet%0d: rv=%0b%0b done=%0b rd1=%0d want 0,0,0,0", k, rd_valid_0, rd_valid_1, done, sa_RD_1);
            end
        end
        set_w(1, 1); tick();
        total++;
        if (fi.in_ready !== 1'b0) begin
            bad++; $display("FAIL rst_mid_half: in_ready=%0b want 0", fi.in_ready);
        end
        set_w(2, 2); tick();
        total++;
        if (fi.in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid_reload: in_ready=%0b want 1", fi.in_ready);
        end
    endtask

    task automatic test_single_beat();
        set_in(9, 19, 1); tick();
        total++;
        if (sa_RD_0 !== 16'd9 || rd_valid_0 !== 1'b1 || rd_valid_1 !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL single_t1: rd0=%0d rv0=%0b rv1=%0b done=%0b want 9,1,0,0", sa_RD_0, rd_valid_0, rd_valid_1, done);
        end
        tick();
        total++;
        if (sa_RD_1 !== 16'd19 || rd_valid_1 !== 1'b1 || done !== 1'b1 || fi.in_ready !== 1'b1 ||
            rd_valid_0 !== 1'b0 || beat_cnt !== 3'd1) begin
            bad++; $display("FAIL single_t2: rd1=%0d rv1=%0b done=%0b in_ready=%0b rv0=%0b cnt=%0d want 19,1,1,1,0,1",
                sa_RD_1, rd_valid_1, done, fi.in_ready, rd_valid_0, beat_cnt);
        end
        tick();
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= 10; k++) begin
            set_in(DW'(k), DW'(k + 100), k == 10); tick();
        end
        total++;
        if (beat_cnt !== 3'd7) begin
            bad++; $display("FAIL saturate: cnt=%0d want 7", beat_cnt);
        end
        tick(); tick();
    endtask

    task automatic test_random();
        int s;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                assert_reset();
                total++;
                if ({rd_valid_0, rd_valid_1, done, sa_load, beat_cnt} !== '0) begin
                    bad++; $display("FAIL rand_reset: rv=%0b%0b done=%0b load=%0b cnt=%0d want 0", rd_valid_0, rd_valid_1, done, sa_load, beat_cnt);
                end
                tick();
                sa_rst = 1'b1;
            end
            if ($urandom_range(0, 4) == 0) set_w(DW'($urandom), DW'($urandom));
            if ($urandom_range(0, 3) != 0) set_in(DW'($urandom), DW'($urandom), $urandom_range(0, 5) == 0);
            else fi.in_last = $urandom_range(0, 1) == 1;
            #1;
            total++;
            if (fi.w_ready !== m_w_ready() || fi.in_ready !== m_in_ready()) begin
                bad++; $display("FAIL rand_ready c%0d: w_ready=%0b in_ready=%0b want %0b,%0b", c, fi.w_ready, fi.in_ready, m_w_ready(), m_in_ready());
            end
            tick();
            s = edge_n % 8;
            total++;
            if ({sa_load, sa_FDi_0, sa_FDi_1} !== {e_load[s], e_fdi0[s], e_fdi1[s]}) begin
                bad++; $display("FAIL rand_weights c%0d: load=%0b fdi=%h,%h want %0b,%h,%h", c, sa_load, sa_FDi_0, sa_FDi_1, e_load[s], e_fdi0[s], e_fdi1[s]);
            end
            total++;
            if ({rd_valid_0, sa_RD_0, rd_valid_1, sa_RD_1} !== {e_rv0[s], e_rd0[s], e_rv1[s], e_rd1[s]}) begin
                bad++; $display("FAIL rand_lanes c%0d: rv0=%0b rd0=%h rv1=%0b rd1=%h want %0b,%h,%0b,%h",
                    c, rd_valid_0, sa_RD_0, rd_valid_1, sa_RD_1, e_rv0[s], e_rd0[s], e_rv1[s], e_rd1[s]);
            end
            total++;
            if (done !== e_done[s] || beat_cnt !== CW'(m_cnt)) begin
                bad++; $display("FAIL rand_status c%0d: done=%0b cnt=%0d want %0b,%0d", c, done, beat_cnt, e_done[s], m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_weight_load();
        test_three_beat();
        test_bubble();
        test_priority();
        test_single_beat();
        test_saturation();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
